// File: rtl/uc_seq.sv
// uc_seq: sequencing control unit for the microc datapath.
// Decodes the opcode and zero flag into datapath controls and a PC write
// enable. It also provides run/halt control, single-step execution, a timed
// WAIT instruction, illegal-opcode trapping and a saturating count of
// retired instructions.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | out of reset, waiting for run
// RUN     | executing; one instruction per enabled cycle
// WAIT    | timed WAIT in progress, PC held until the counter expires
// HALT    | PC parked on the HALT instruction until run
// ERROR   | illegal opcode trapped, only reset leaves
module uc_seq #(
    parameter int unsigned WAIT_CYCLES = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [5:0]       opcode_i,
    input  logic             z_i,
    input  logic             run_i,
    input  logic             step_mode_i,
    input  logic             step_i,
    output logic             s_inc_o,
    output logic             s_inm_o,
    output logic             we3_o,
    output logic             wez_o,
    output logic [2:0]       op_o,
    output logic             pc_we_o,
    output logic             halted_o,
    output logic             err_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HALT  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    // WAIT occupies one RUN cycle plus WAIT_CYCLES cycles in ST_WAIT; the
    // last of those (counter at zero) advances the PC.
    localparam logic [7:0]       WAIT_LOAD = 8'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [5:0] OPC_LI   = 6'b000000;
    localparam logic [5:0] OPC_J    = 6'b000001;
    localparam logic [5:0] OPC_JZ   = 6'b000010;
    localparam logic [5:0] OPC_JNZ  = 6'b000011;
    localparam logic [5:0] OPC_NOP  = 6'b000100;
    localparam logic [5:0] OPC_WAIT = 6'b000101;
    localparam logic [5:0] OPC_HALT = 6'b000110;

    state_t           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             exec;

    logic       s_inc, s_inm, we3, wez, pc_we, halted, err;
    logic [2:0] op;

    // Instruction may execute only in RUN, and in step mode only while step is high.
    assign exec = (state_q == ST_RUN) && (!step_mode_i || step_i);

    // Next-state and control decode; every path starts from inhibited outputs.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        s_inc   = 1'b1;
        s_inm   = 1'b0;
        we3     = 1'b0;
        wez     = 1'b0;
        op      = 3'b000;
        pc_we   = 1'b0;
        halted  = 1'b0;
        err     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (exec) begin
                    casez (opcode_i)
                        6'b1?????: begin
                            op    = opcode_i[4:2];
                            we3   = 1'b1;
                            wez   = 1'b1;
                            pc_we = 1'b1;
                        end
                        OPC_LI: begin
                            s_inm = 1'b1;
                            we3   = 1'b1;
                            pc_we = 1'b1;
                        end
                        OPC_J: begin
                            s_inc = 1'b0;
                            pc_we = 1'b1;
                        end
                        OPC_JZ: begin
                            s_inc = ~z_i;
                            pc_we = 1'b1;
                        end
                        OPC_JNZ: begin
                            s_inc = z_i;
                            pc_we = 1'b1;
                        end
                        OPC_NOP: begin
                            pc_we = 1'b1;
                        end
                        OPC_WAIT: begin
                            wait_d  = WAIT_LOAD;
                            state_d = ST_WAIT;
                        end
                        OPC_HALT: begin
                            state_d = ST_HALT;
                        end
                        default: begin
                            state_d = ST_ERROR;
                        end
                    endcase
                end
            end
            ST_WAIT: begin
                // step_mode deliberately not consulted: a WAIT runs to completion.
                if (wait_q != 8'd0) begin
                    wait_d = wait_q - 8'd1;
                end else begin
                    pc_we   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
                // Step past the HALT instruction in the resume cycle itself.
                if (run_i) begin
                    pc_we   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_ERROR: begin
                halted = 1'b1;
                err    = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset is synchronous, so gate the outputs during the reset cycle itself.
        if (reset_i) begin
            s_inc  = 1'b1;
            s_inm  = 1'b0;
            we3    = 1'b0;
            wez    = 1'b0;
            op     = 3'b000;
            pc_we  = 1'b0;
            halted = 1'b0;
            err    = 1'b0;
        end
    end

    // Retired-instruction count follows pc_we and saturates instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (pc_we && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // State, wait counter and instruction counter registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            wait_q  <= 8'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s_inc_o     = s_inc;
    assign s_inm_o     = s_inm;
    assign we3_o       = we3;
    assign wez_o       = wez;
    assign op_o        = op;
    assign pc_we_o     = pc_we;
    assign halted_o    = halted;
    assign err_o       = err;
    assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_uc_seq.sv
// Directed bench for uc_seq with a scoreboard of expected outputs per cycle.
module tb_uc_seq;

    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic [2:0] op;
        logic       pc_we;
        logic       halted;
        logic       err;
    } exp_t;

    typedef struct {
        exp_t             e;
        logic [CNT_W-1:0] cnt;
        string            tag;
    } sb_t;

    logic             clk;
    logic             reset;
    logic [5:0]       opcode;
    logic             z, run, step_mode, step;
    logic             s_inc, s_inm, we3, wez, pc_we, halted, err;
    logic [2:0]       op;
    logic [CNT_W-1:0] instr_cnt;

    sb_t              sb_q[$];
    logic [CNT_W-1:0] model_cnt;
    int               checks = 0;
    int               errors = 0;

    uc_seq #(.WAIT_CYCLES(4), .CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .opcode_i    (opcode),
        .z_i         (z),
        .run_i       (run),
        .step_mode_i (step_mode),
        .step_i      (step),
        .s_inc_o     (s_inc),
        .s_inm_o     (s_inm),
        .we3_o       (we3),
        .wez_o       (wez),
        .op_o        (op),
        .pc_we_o     (pc_we),
        .halted_o    (halted),
        .err_o       (err),
        .instr_cnt_o (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t ex(input logic si, input logic sm, input logic w3, input logic wz,
                                input logic [2:0] o, input logic pw, input logic h, input logic e);
        exp_t r;
        r.s_inc = si; r.s_inm = sm; r.we3 = w3; r.wez = wz;
        r.op = o; r.pc_we = pw; r.halted = h; r.err = e;
        return r;
    endfunction

    // One clock cycle: drive, queue the expectation, compare mid-cycle, advance.
    task automatic cyc(input logic [5:0] opc, input logic zz, input logic rr,
                       input logic smm, input logic stt, input exp_t e, input string tag);
        sb_t  it;
        exp_t obs;
        opcode = opc; z = zz; run = rr; step_mode = smm; step = stt;
        it.e = e; it.cnt = model_cnt; it.tag = tag;
        sb_q.push_back(it);
        @(negedge clk);
        it  = sb_q.pop_front();
        obs = {s_inc, s_inm, we3, wez, op, pc_we, halted, err};
        checks++;
        assert (obs === it.e) else begin
            errors++;
            $error("FAIL %s ctrl got %b want %b", it.tag, obs, it.e);
        end
        checks++;
        assert (instr_cnt === it.cnt) else begin
            errors++;
            $error("FAIL %s instr_cnt got %0d want %0d", it.tag, instr_cnt, it.cnt);
        end
        @(posedge clk);
        #1;
        if (reset) model_cnt = '0;
        else if (e.pc_we && model_cnt != '1) model_cnt = model_cnt + 1'b1;
    endtask

    initial begin : stim
        exp_t INH, HLT, ERR;
        INH = ex(1, 0, 0, 0, 3'b000, 0, 0, 0);
        HLT = ex(1, 0, 0, 0, 3'b000, 0, 1, 0);
        ERR = ex(1, 0, 0, 0, 3'b000, 0, 1, 1);

        reset = 1'b1; opcode = 6'd0; z = 1'b0; run = 1'b0; step_mode = 1'b0; step = 1'b0;
        model_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        cyc(6'b100100, 0, 1, 0, 0, INH, "in_reset");
        reset = 1'b0;

        // IDLE holds, even with an executable opcode present.
        for (int i = 0; i < 3; i++) cyc(6'b100100, 0, 0, 0, 0, INH, "idle");
        cyc(6'b100100, 0, 1, 0, 0, INH, "idle_run");
        cyc(6'b100100, 0, 0, 0, 0, ex(1, 0, 1, 1, 3'b001, 1, 0, 0), "alu_001");
        cyc(6'b111100, 0, 0, 0, 0, ex(1, 0, 1, 1, 3'b111, 1, 0, 0), "alu_111");

        // Branches, jump and load-immediate.
        cyc(6'b000010, 1, 0, 0, 0, ex(0, 0, 0, 0, 3'b000, 1, 0, 0), "jz_taken");
        cyc(6'b000010, 0, 0, 0, 0, ex(1, 0, 0, 0, 3'b000, 1, 0, 0), "jz_fall");
        cyc(6'b000011, 0, 0, 0, 0, ex(0, 0, 0, 0, 3'b000, 1, 0, 0), "jnz_taken");
        cyc(6'b000011, 1, 0, 0, 0, ex(1, 0, 0, 0, 3'b000, 1, 0, 0), "jnz_fall");
        cyc(6'b000001, 1, 0, 0, 0, ex(0, 0, 0, 0, 3'b000, 1, 0, 0), "jump");
        cyc(6'b000000, 0, 0, 0, 0, ex(1, 1, 1, 0, 3'b000, 1, 0, 0), "li");

        // WAIT: four held cycles then the advance; step_mode and run meddle midway.
        cyc(6'b000101, 0, 0, 0, 0, INH, "wait_c1");
        cyc(6'b000101, 0, 1, 1, 0, INH, "wait_c2");
        cyc(6'b000101, 0, 0, 1, 0, INH, "wait_c3");
        cyc(6'b000101, 0, 0, 0, 0, INH, "wait_c4");
        cyc(6'b000101, 0, 0, 1, 0, ex(1, 0, 0, 0, 3'b000, 1, 0, 0), "wait_done");

        // HALT and resume.
        cyc(6'b000110, 0, 0, 0, 0, INH, "halt_exec");
        for (int i = 0; i < 3; i++) cyc(6'b000110, 0, 0, 0, 0, HLT, "halted");
        cyc(6'b000110, 0, 1, 0, 0, ex(1, 0, 0, 0, 3'b000, 1, 1, 0), "halt_resume");
        cyc(6'b000100, 0, 0, 0, 0, ex(1, 0, 0, 0, 3'b000, 1, 0, 0), "nop_after_halt");

        // Single-step mode.
        for (int i = 0; i < 5; i++) cyc(6'b000000, 0, 0, 1, 0, INH, "step_hold");
        cyc(6'b000000, 0, 0, 1, 1, ex(1, 1, 1, 0, 3'b000, 1, 0, 0), "step_li");
        cyc(6'b000000, 0, 0, 1, 0, INH, "step_idle");
        cyc(6'b000100, 0, 0, 1, 1, ex(1, 0, 0, 0, 3'b000, 1, 0, 0), "step_held1");
        cyc(6'b000100, 0, 0, 1, 1, ex(1, 0, 0, 0, 3'b000, 1, 0, 0), "step_held2");

        // Illegal opcode trap; run cannot leave ERROR, reset does.
        cyc(6'b010000, 0, 0, 0, 0, INH, "illegal_exec");
        cyc(6'b010000, 0, 1, 0, 0, ERR, "error_run1");
        cyc(6'b000100, 0, 1, 0, 0, ERR, "error_run2");
        reset = 1'b1;
        cyc(6'b000100, 0, 1, 0, 0, INH, "error_reset");
        reset = 1'b0;
        cyc(6'b000100, 0, 0, 0, 0, INH, "idle_after_err");

        // Second illegal encoding, then reset mid-WAIT.
        cyc(6'b000111, 0, 1, 0, 0, INH, "idle_run2");
        cyc(6'b000111, 0, 0, 0, 0, INH, "illegal_000111");
        cyc(6'b000111, 0, 0, 0, 0, ERR, "error_000111");
        reset = 1'b1;
        cyc(6'b000100, 0, 1, 0, 0, INH, "reset2");
        reset = 1'b0;
        cyc(6'b000100, 0, 1, 0, 0, INH, "idle_run3");
        cyc(6'b000101, 0, 0, 0, 0, INH, "wait_then_reset");
        cyc(6'b000101, 0, 0, 0, 0, INH, "wait_mid");
        reset = 1'b1;
        cyc(6'b000101, 0, 0, 0, 0, INH, "reset_mid_wait");
        reset = 1'b0;
        cyc(6'b000100, 0, 0, 0, 0, INH, "idle_after_wait_reset");

        // Saturation: 20 NOPs with a 4-bit counter stop at 15.
        cyc(6'b000100, 0, 1, 0, 0, INH, "idle_run4");
        for (int i = 0; i < 20; i++) cyc(6'b000100, 0, 0, 0, 0, ex(1, 0, 0, 0, 3'b000, 1, 0, 0), "nop_sat");
        cyc(6'b000110, 0, 0, 0, 0, INH, "sat_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time bound so the bench can never hang.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uc_seq.md
Name: uc_seq

Overview:
- Sequencing control unit for the microc datapath. It decodes the 6-bit Opcode and the zero flag z from microc and drives s_inc, s_inm, we3, wez, Op and a new PC write enable, pc_we. The microc PC register gains an enable input; the PC loads only when pc_we=1.
- Adds run/halt control, a single-step mode, a timed WAIT instruction, illegal-opcode trapping and a retired-instruction counter.
- Sits beside microc at the top level and replaces the hand-driven control signals used in bring-up.

Parameters:
- WAIT_CYCLES, 4: total cycles occupied by a WAIT instruction is WAIT_CYCLES+1. Legal range is 1..255.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Opcode  in  6  current instruction opcode from microc.
- z  in  1  zero flag from microc.
- run  in  1  start/resume request, sampled each cycle.
- step_mode  in  1  1 = single-step mode.
- step  in  1  in step mode, permits one instruction to execute this cycle.
- s_inc  out  1  PC source: 1 = PC+1, 0 = jump target.
- s_inm  out  1  register write source: 1 = immediate, 0 = ALU.
- we3  out  1  register file write enable.
- wez  out  1  zero-flag write enable.
- Op  out  3  ALU operation.
- pc_we  out  1  PC write enable.
- halted  out  1  1 in HALT or ERROR.
- err  out  1  1 in ERROR.
- instr_cnt  out  CNT_W  retired-instruction count, saturating.

Behaviour:
- States: IDLE, RUN, WAIT, HALT, ERROR. Reset enters IDLE.
- Reset values: instr_cnt=0, wait counter=0, halted=0, err=0.
- "Inhibited outputs": s_inc=1, s_inm=0, we3=0, wez=0, Op=000, pc_we=0. These are the outputs during reset and in every cycle without an active execute.
- Control outputs are combinational from state, Opcode, z, step_mode and step. State, wait counter and instr_cnt are registered.
- Execute-enable: exec = (state==RUN) & (~step_mode | step).
- Decode when exec=1:
  - Opcode[5]=1: ALU op. Op=Opcode[4:2], we3=1, wez=1, s_inm=0, s_inc=1, pc_we=1.
  - 000000 LI: s_inm=1, we3=1, wez=0, s_inc=1, pc_we=1.
  - 000001 J: s_inc=0, pc_we=1, no writes.
  - 000010 JZ: s_inc=~z, pc_we=1.
  - 000011 JNZ: s_inc=z, pc_we=1.
  - 000100 NOP: s_inc=1, pc_we=1.
  - 000101 WAIT: pc_we=0; load wait counter with WAIT_CYCLES-1; go to WAIT.
  - 000110 HALT: pc_we=0; go to HALT.
  - All other opcodes (000111, 001xxx..011xxx): inhibited outputs; go to ERROR.
- IDLE: outputs inhibited. run=1 goes to RUN on the next cycle.
- WAIT:
  - Counts every cycle, ignoring step_mode.
  - While counter≠0: decrement; outputs inhibited.
  - At counter=0: s_inc=1, pc_we=1, return to RUN.
  - Total WAIT latency is WAIT_CYCLES+1 cycles, counted from its first RUN cycle.
- HALT:
  - halted=1; outputs inhibited; PC stays on the HALT instruction.
  - run=1: in that same cycle drive pc_we=1, s_inc=1 (no register or flag writes) to step past HALT, then go to RUN. HALT retires at this point.
- ERROR: halted=1, err=1, outputs inhibited. Only reset leaves ERROR; run is ignored.
- instr_cnt: +1 in each cycle where pc_we=1. It saturates at 2^CNT_W-1 and does not wrap. HALT is counted on resume; illegal opcodes are never counted.
- Step mode: in RUN with step_mode=1 and step=0, outputs are inhibited and no state changes. Each cycle with step=1 executes exactly one instruction. A held step executes one instruction per cycle.
- Simultaneous events:
  - reset dominates everything.
  - run is ignored in RUN and WAIT.
  - Toggling step_mode mid-WAIT has no effect on the WAIT.
- Reset mid-WAIT or mid-HALT: next state IDLE, counter cleared, instr_cnt cleared.

Test Plan:
- Reset, hold run=0 for 3 cycles -> IDLE; pc_we=0, we3=0, halted=0, instr_cnt=0. Pulse run with Opcode=100100 -> next cycle Op=001, we3=1, wez=1, pc_we=1; instr_cnt=1.
- In RUN: Opcode=000010 with z=1 -> s_inc=0, pc_we=1. Same opcode with z=0 -> s_inc=1. Opcode=000011 with z=0 -> s_inc=0.
- WAIT with WAIT_CYCLES=4 -> pc_we=0 for 4 cycles, then pc_we=1 and s_inc=1 on the 5th cycle; instr_cnt increments by 1 only on that cycle.
- Opcode=000110 -> halted=1, pc_we=0 indefinitely. Pulse run -> one cycle with pc_we=1, s_inc=1, we3=0; then RUN, halted=0.
- Opcode=010000 -> err=1, halted=1. run=1 stays in ERROR; reset -> IDLE, err=0.
- step_mode=1 in RUN with Opcode=000000, step low for 5 cycles -> we3=0, pc_we=0 throughout. One-cycle step pulse -> exactly one cycle with s_inm=1, we3=1, pc_we=1; instr_cnt=+1. Also: with CNT_W=4, 20 NOPs -> instr_cnt stops at 15.
